noc_term_injector: RTL and testbench

Terminal-side injection scheduler for the 2D-mesh wormhole XY NoC. Shares one node terminal input channel between REQ_N local requesters. Round-robin arbitration picks a requester, emits a HEAD flit carrying the destination, then streams the requester's payload words as BODY flits closed by a TAIL flit. The grant is locked for the whole packet, so packets from different requesters never interleave on the channel.

---
 rtl/noc_term_injector.sv | 204 ++++++++++++++++++++
 tb/tb_noc_term_injector.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_term_injector.sv
// Terminal-side injection scheduler: round-robin shares one NoC terminal input
// channel between REQ_N requesters, emitting HEAD / BODY... / TAIL wormhole packets.
module noc_term_injector #(
    parameter int REQ_N      = 4,
    parameter int CHANNEL_W  = 8,
    parameter int FLIT_ID_W  = 2,
    parameter int ROW_ADDR_W = 2,
    parameter int COL_ADDR_W = 2,
    parameter int MAX_BODY   = 16
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic [REQ_N-1:0]                             req_vld_i,
    input  logic [REQ_N*(ROW_ADDR_W+COL_ADDR_W)-1:0]     req_dst_i,
    input  logic [REQ_N*(CHANNEL_W-FLIT_ID_W)-1:0]       req_data_i,
    input  logic [REQ_N-1:0]                             req_dvld_i,
    input  logic [REQ_N-1:0]                             req_last_i,
    output logic [REQ_N-1:0]                             req_drdy_o,
    output logic [REQ_N-1:0]                             hdr_ack_o,
    output logic [REQ_N-1:0]                             grant_o,
    output logic [CHANNEL_W-1:0]                         och_data_o,
    output logic                                         och_vld_o,
    input  logic                                         och_rdy_i,
    output logic                                         trunc_o,
    output logic [1:0]                                   fsm_state_o
);

    localparam int DST_W  = ROW_ADDR_W + COL_ADDR_W;
    localparam int DATA_W = CHANNEL_W - FLIT_ID_W;
    localparam int IDX_W  = $clog2(REQ_N);
    localparam int CNT_W  = $clog2(MAX_BODY + 1);

    localparam logic [FLIT_ID_W-1:0] ID_HEAD = FLIT_ID_W'(1);
    localparam logic [FLIT_ID_W-1:0] ID_BODY = FLIT_ID_W'(2);
    localparam logic [FLIT_ID_W-1:0] ID_TAIL = FLIT_ID_W'(3);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HEAD  = 2'd1,
        S_BODY  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [REQ_N-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [DST_W-1:0]     dst_q, dst_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 trunc_q, trunc_d;

    logic                 arb_found;
    logic [IDX_W-1:0]     arb_idx;
    logic [IDX_W:0]       cand;
    logic [REQ_N-1:0]     win_oh;
    logic [DST_W-1:0]     win_dst;

    logic [DATA_W-1:0]    g_data;
    logic                 g_dvld;
    logic                 g_last;
    logic                 tail_now;
    logic [IDX_W-1:0]     ptr_next;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 0; k < REQ_N; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(REQ_N)) begin
                cand = cand - (IDX_W+1)'(REQ_N);
            end
            if (!arb_found && req_vld_i[cand[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        win_oh  = REQ_N'(1) << arb_idx;
        win_dst = '0;
        for (int i = 0; i < REQ_N; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                win_dst = req_dst_i[i*DST_W +: DST_W];
            end
        end
    end

    // Payload mux driven by the one-hot grant register.
    always_comb begin
        g_data = '0;
        g_dvld = 1'b0;
        g_last = 1'b0;
        for (int i = 0; i < REQ_N; i++) begin
            if (grant_q[i]) begin
                g_data = req_data_i[i*DATA_W +: DATA_W];
                g_dvld = req_dvld_i[i];
                g_last = req_last_i[i];
            end
        end
    end

    assign tail_now = g_last || (cnt_q == CNT_W'(MAX_BODY - 1));
    assign ptr_next = (gidx_q == IDX_W'(REQ_N - 1)) ? '0 : gidx_q + IDX_W'(1);

    // Handshake: a flit moves when och_vld_o && och_rdy_i at a rising edge; a
    // payload word is consumed when req_dvld_i[g] && req_drdy_o[g] at a rising edge.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        dst_d      = dst_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        trunc_d    = trunc_q;
        och_vld_o  = 1'b0;
        och_data_o = '0;
        req_drdy_o = '0;
        hdr_ack_o  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    grant_d = win_oh;
                    gidx_d  = arb_idx;
                    dst_d   = win_dst;
                    state_d = S_HEAD;
                end
            end

            S_HEAD: begin
                och_vld_o  = 1'b1;
                och_data_o = {ID_HEAD, DATA_W'(dst_q)};
                if (och_rdy_i) begin
                    hdr_ack_o = grant_q;
                    cnt_d     = '0;
                    state_d   = S_BODY;
                end
            end

            S_BODY: begin
                och_vld_o  = g_dvld;
                req_drdy_o = grant_q & {REQ_N{och_rdy_i}};
                if (g_dvld) begin
                    och_data_o = {(tail_now ? ID_TAIL : ID_BODY), g_data};
                end
                if (g_dvld && och_rdy_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (tail_now) begin
                        if (g_last) begin
                            grant_d  = '0;
                            rr_ptr_d = ptr_next;
                            state_d  = S_IDLE;
                        end else begin
                            // Packet hit the length cap: close it and swallow the rest.
                            trunc_d = 1'b1;
                            state_d = S_DRAIN;
                        end
                    end
                end
            end

            S_DRAIN: begin
                req_drdy_o = grant_q;
                if (g_dvld && g_last) begin
                    grant_d  = '0;
                    rr_ptr_d = ptr_next;
                    state_d  = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            dst_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            trunc_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            dst_q    <= dst_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            trunc_q  <= trunc_d;
        end
    end

    assign grant_o     = grant_q;
    assign trunc_o     = trunc_q;
    assign fsm_state_o = state_q;

endmodule

// File: tb/tb_noc_term_injector.sv
// Randomized bench for noc_term_injector: requester drivers, a packet-level
// round-robin reference model producing the expected flit stream, and directed cases.
module tb_noc_term_injector;

    localparam int REQ_N = 4;
    localparam int MAXB  = 4;
    localparam int DW    = 6;
    localparam int DSTW  = 4;
    localparam int NP    = 128;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [REQ_N-1:0]      req_vld = '0;
    logic [REQ_N*DSTW-1:0] req_dst = '0;
    logic [REQ_N*DW-1:0]   req_data = '0;
    logic [REQ_N-1:0]      req_dvld = '0;
    logic [REQ_N-1:0]      req_last = '0;
    logic [REQ_N-1:0]      req_drdy, hdr_ack, grant;
    logic [7:0]            och_data;
    logic                  och_vld;
    logic                  och_rdy = 1'b1;
    logic                  trunc;
    logic [1:0]            fsm_state;

    noc_term_injector #(
        .REQ_N(REQ_N), .CHANNEL_W(8), .FLIT_ID_W(2),
        .ROW_ADDR_W(2), .COL_ADDR_W(2), .MAX_BODY(MAXB)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_vld_i(req_vld), .req_dst_i(req_dst), .req_data_i(req_data),
        .req_dvld_i(req_dvld), .req_last_i(req_last), .req_drdy_o(req_drdy),
        .hdr_ack_o(hdr_ack), .grant_o(grant), .och_data_o(och_data),
        .och_vld_o(och_vld), .och_rdy_i(och_rdy), .trunc_o(trunc),
        .fsm_state_o(fsm_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Packet store; p_st: 0 pending header, 1 streaming payload, 2 finished.
    int         npkt = 0;
    int         p_req[NP];
    int         p_len[NP];
    logic [3:0] p_dst[NP];
    logic [5:0] p_word[NP][8];
    int         p_st[NP];

    int cur[REQ_N]   = '{-1, -1, -1, -1};
    int cur_w[REQ_N] = '{0, 0, 0, 0};
    bit dv[REQ_N]    = '{0, 0, 0, 0};

    int   m_ptr     = 0;
    bit   exp_trunc = 0;
    logic [7:0] exp_q[$];
    int         exp_own_q[$];

    int         head_own[$];
    int         head_cyc[$];
    logic [7:0] obs_flit[$];
    int         last_cyc;
    bit         prev_stall;
    logic [7:0] prev_flit;

    task automatic add_pkt(input int r, input int len, input logic [3:0] dst, output int idx);
        idx        = npkt;
        p_req[idx] = r;
        p_len[idx] = len;
        p_dst[idx] = dst;
        p_st[idx]  = 0;
        for (int j = 0; j < 8; j++) p_word[idx][j] = 6'($urandom_range(0, 63));
        npkt++;
    endtask

    function automatic int front_pending(input int r);
        for (int n = 0; n < npkt; n++)
            if (p_req[n] == r && p_st[n] == 0) return n;
        return -1;
    endfunction

    function automatic bit all_done();
        for (int n = 0; n < npkt; n++)
            if (p_st[n] != 2) return 0;
        return exp_q.size() == 0;
    endfunction

    // Packet-level model: pending requesters never change once loaded, so the
    // round-robin order and every packet's flits are known up front.
    task automatic build_expected();
        bit used[NP];
        int w, k, r, nb;
        logic [1:0] id;
        for (int n = 0; n < NP; n++) used[n] = (n >= npkt) || (p_st[n] != 0);
        while (1) begin
            w = -1;
            k = -1;
            for (int s = 0; s < REQ_N; s++) begin
                r = (m_ptr + s) % REQ_N;
                for (int n = 0; n < npkt; n++)
                    if (w < 0 && !used[n] && p_req[n] == r) begin
                        w = r;
                        k = n;
                    end
            end
            if (w < 0) break;
            used[k] = 1;
            m_ptr   = (w + 1) % REQ_N;
            exp_q.push_back({2'b01, 2'b00, p_dst[k]});
            exp_own_q.push_back(w);
            nb = (p_len[k] < MAXB) ? p_len[k] : MAXB;
            for (int j = 0; j < nb; j++) begin
                id = (j == p_len[k] - 1 || j == MAXB - 1) ? 2'b11 : 2'b10;
                exp_q.push_back({id, p_word[k][j]});
                exp_own_q.push_back(w);
            end
            if (p_len[k] > MAXB) exp_trunc = 1;
        end
    endtask

    task automatic drive_inputs(input int cyc, input int dv_pct, input int rdy_pct,
                                input int st_s, input int st_l);
        int k;
        for (int i = 0; i < REQ_N; i++) begin
            k = front_pending(i);
            req_vld[i] = (k >= 0);
            if (k >= 0) req_dst[i*DSTW +: DSTW] = p_dst[k];
            else        req_dst[i*DSTW +: DSTW] = '0;
            if (cur[i] >= 0) begin
                if (!dv[i]) dv[i] = ($urandom_range(0, 99) < dv_pct);
                req_data[i*DW +: DW] = p_word[cur[i]][cur_w[i]];
                req_last[i] = (cur_w[i] == p_len[cur[i]] - 1);
            end else begin
                dv[i] = 0;
                req_data[i*DW +: DW] = '0;
                req_last[i] = 1'b0;
            end
            req_dvld[i] = dv[i];
        end
        if (cyc >= st_s && cyc < st_s + st_l) och_rdy = 1'b0;
        else och_rdy = ($urandom_range(0, 99) < rdy_pct);
    endtask

    task automatic sample_update(input int cyc);
        logic [7:0] ef;
        int         own;
        int         k;
        if (prev_stall) begin
            check_eq("hold_vld", och_vld, 1);
            check_eq("hold_data", och_data, prev_flit);
        end
        if (!och_vld) check_eq("idle_data", och_data, 0);
        if (och_vld && !och_rdy) begin
            check_eq("bp_drdy", req_drdy, 0);
            check_eq("bp_ack", hdr_ack, 0);
        end
        if (och_vld && och_rdy) begin
            check_eq("flit_avail", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                ef  = exp_q.pop_front();
                own = exp_own_q.pop_front();
                check_eq("flit", och_data, ef);
                check_eq("grant", grant, 32'(1) << own);
                if (ef[7:6] == 2'b01) begin
                    check_eq("hdr_ack", hdr_ack, 32'(1) << own);
                    head_own.push_back(own);
                    head_cyc.push_back(cyc);
                end
            end
            obs_flit.push_back(och_data);
            last_cyc = cyc;
        end
        prev_stall = och_vld && !och_rdy;
        prev_flit  = och_data;
        for (int i = 0; i < REQ_N; i++) begin
            if (req_drdy[i] && req_dvld[i]) begin
                check_eq("take_streaming", cur[i] >= 0, 1);
                if (cur[i] >= 0) begin
                    cur_w[i]++;
                    dv[i] = 0;
                    if (cur_w[i] == p_len[cur[i]]) begin
                        p_st[cur[i]] = 2;
                        cur[i] = -1;
                    end
                end
            end
            if (hdr_ack[i]) begin
                k = front_pending(i);
                check_eq("ack_pending", k >= 0, 1);
                if (k >= 0) begin
                    p_st[k]  = 1;
                    cur[i]   = k;
                    cur_w[i] = 0;
                    dv[i]    = 0;
                end
            end
        end
    endtask

    task automatic run_pkts(input int dv_pct, input int rdy_pct, input int st_s, input int st_l);
        bit done;
        build_expected();
        head_own.delete();
        head_cyc.delete();
        obs_flit.delete();
        last_cyc   = -1;
        prev_stall = 0;
        done       = 0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(posedge clk);
            #1;
            drive_inputs(cyc, dv_pct, rdy_pct, st_s, st_l);
            @(negedge clk);
            sample_update(cyc);
            done = all_done();
        end
        check_eq("run_complete", done, 1);
        if (done) begin
            @(posedge clk);
            #1;
            och_rdy = 1'b1;
            @(negedge clk);
            check_eq("end_grant", grant, 0);
            check_eq("end_state_idle", fsm_state, 0);
            check_eq("end_vld", och_vld, 0);
            check_eq("end_trunc", trunc, exp_trunc);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_grant"}, grant, 0);
        check_eq({tag, "_vld"}, och_vld, 0);
        check_eq({tag, "_data"}, och_data, 0);
        check_eq({tag, "_drdy"}, req_drdy, 0);
        check_eq({tag, "_ack"}, hdr_ack, 0);
        check_eq({tag, "_trunc"}, trunc, 0);
        check_eq({tag, "_state"}, fsm_state, 0);
    endtask

    initial begin
        int idx;
        logic [7:0] t1_exp[4];

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;

        // Single packet from requester 2.
        add_pkt(2, 3, 4'b0110, idx);
        p_word[idx][0] = 6'h05;
        p_word[idx][1] = 6'h0A;
        p_word[idx][2] = 6'h15;
        run_pkts(100, 100, -1, 0);
        t1_exp = '{8'h46, 8'h85, 8'h8A, 8'hD5};
        check_eq("single_nflits", obs_flit.size(), 4);
        for (int j = 0; j < 4 && j < obs_flit.size(); j++) check_eq("single_flit", obs_flit[j], t1_exp[j]);
        if (head_cyc.size() > 0) check_eq("single_head_cyc", head_cyc[0], 1);
        check_eq("single_tail_cyc", last_cyc, 4);

        // Round-robin across all requesters (requester 0 has a second packet queued).
        // Reset first so the pointer starts at 0.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        m_ptr = 0;
        exp_trunc = 0;
        add_pkt(0, 1, 4'h3, idx);
        add_pkt(1, 1, 4'h5, idx);
        add_pkt(2, 1, 4'h9, idx);
        add_pkt(3, 1, 4'hC, idx);
        add_pkt(0, 1, 4'hF, idx);
        run_pkts(100, 100, -1, 0);
        check_eq("rr_nheads", head_own.size(), 5);
        for (int j = 0; j < head_own.size(); j++) check_eq("rr_order", head_own[j], j % REQ_N);
        for (int j = 1; j < head_cyc.size(); j++) check_eq("rr_spacing", head_cyc[j] - head_cyc[j-1], 3);

        // Backpressure: channel not ready for cycles 3..5 while BODY flits wait.
        add_pkt(1, 4, 4'h7, idx);
        run_pkts(100, 100, 3, 3);
        check_eq("bp_nflits", obs_flit.size(), 5);
        check_eq("bp_tail_cyc", last_cyc, 8);

        // Truncation: 6-word packet against the 4-flit cap.
        check_eq("pre_trunc", trunc, 0);
        add_pkt(0, 6, 4'hB, idx);
        run_pkts(100, 100, -1, 0);
        check_eq("trunc_nflits", obs_flit.size(), 5);
        if (obs_flit.size() == 5) check_eq("trunc_tail", obs_flit[4], {2'b11, p_word[idx][3]});
        check_eq("trunc_flag", trunc, 1);

        // Pointer wrap: requester 2 moves the pointer to 3, then 3 and 0 compete.
        add_pkt(2, 1, 4'h1, idx);
        run_pkts(100, 100, -1, 0);
        add_pkt(0, 2, 4'h2, idx);
        add_pkt(3, 2, 4'h4, idx);
        run_pkts(100, 100, -1, 0);
        check_eq("wrap_nheads", head_own.size(), 2);
        if (head_own.size() == 2) begin
            check_eq("wrap_first", head_own[0], 3);
            check_eq("wrap_second", head_own[1], 0);
        end

        // Reset in the middle of a BODY stream from requester 3.
        @(posedge clk); #1;
        req_vld = 4'b1000;
        req_dst[3*DSTW +: DSTW] = 4'hA;
        och_rdy = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rst_head", och_data, {2'b01, 2'b00, 4'hA});
        check_eq("rst_head_ack", hdr_ack, 4'b1000);
        @(posedge clk); #1;
        req_vld = '0;
        req_dvld[3] = 1'b1;
        req_data[3*DW +: DW] = 6'h11;
        @(negedge clk);
        check_eq("rst_body", och_data, {2'b10, 6'h11});
        check_eq("rst_body_drdy", req_drdy, 4'b1000);
        @(posedge clk); #1;
        req_data[3*DW +: DW] = 6'h12;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_quiet("midrst");
        @(posedge clk); #1;
        req_dvld = '0;
        req_data = '0;
        m_ptr = 0;
        exp_trunc = 0;
        add_pkt(2, 2, 4'h6, idx);
        add_pkt(0, 2, 4'h8, idx);
        run_pkts(100, 100, -1, 0);
        if (head_own.size() > 0) check_eq("midrst_first", head_own[0], 0);

        // Randomized traffic with random payload gaps and channel backpressure.
        for (int round = 0; round < 4; round++) begin
            for (int i = 0; i < REQ_N; i++) begin
                int n;
                n = $urandom_range(0, 3);
                for (int p = 0; p < n; p++)
                    add_pkt(i, $urandom_range(1, 6), 4'($urandom_range(0, 15)), idx);
            end
            run_pkts(70, 70, -1, 0);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
